// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush and ID-stage forwarding control for the RV32E pipeline (optional counters: HAZARD_PERF_CNT_EN)
module hazard_control_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rs1_ID,
  input  logic [3:0] rs2_ID,
  input  logic       rs1_used_ID,
  input  logic       rs2_used_ID,
  input  logic [3:0] rd_EX,
  input  logic       regfile_we_EX,
  input  logic       mem_read_EX,
  input  logic       branch_taken_EX,
  input  logic [3:0] rd_MEM,
  input  logic       regfile_we_MEM,
  output logic       stall_pc,
  output logic       stall_IF,
  output logic       invalid_IF,
  output logic       stall,
  output logic       invalid_ID,
  output logic       redirect,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
  state_t     state;
  logic [2:0] flush_cnt;
  logic       ex_killed;
  logic       br, lu, in_flush, first_flush, ex_fwd_ok, mem_fwd_ok;
  // hazard decode and output generation; reset masks everything except the two invalids
  always_comb begin
    br          = branch_taken_EX & ~ex_killed;
    in_flush    = state == FLUSH;
    first_flush = in_flush & (flush_cnt == RELOAD);
    lu          = ~in_flush & ~br & mem_read_EX & regfile_we_EX & ~ex_killed & (|rd_EX) &
                  ((rs1_used_ID & (rs1_ID == rd_EX)) | (rs2_used_ID & (rs2_ID == rd_EX)));
    ex_fwd_ok   = regfile_we_EX & ~ex_killed & ~mem_read_EX & (|rd_EX);
    mem_fwd_ok  = regfile_we_MEM & (|rd_MEM);
    redirect    = rst_n & br;
    stall_pc    = rst_n & lu;
    stall_IF    = rst_n & lu;
    stall       = 1'b0;
    invalid_IF  = ~rst_n | br | in_flush;
    invalid_ID  = ~rst_n | br | first_flush | lu;
    fwd_rs1_sel = !rst_n ? 2'b00 : (ex_fwd_ok && rd_EX == rs1_ID) ? 2'b01 :
                  (mem_fwd_ok && rd_MEM == rs1_ID) ? 2'b10 : 2'b00;
    fwd_rs2_sel = !rst_n ? 2'b00 : (ex_fwd_ok && rd_EX == rs2_ID) ? 2'b01 :
                  (mem_fwd_ok && rd_MEM == rs2_ID) ? 2'b10 : 2'b00;
  end
  // flush FSM and EX-validity tracking; a branch (re)loads the flush window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
      ex_killed <= 1'b1;
    end else begin
      ex_killed <= invalid_ID | stall;
      if (br) begin
        state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        flush_cnt <= RELOAD;
      end else if (in_flush) begin
        flush_cnt <= flush_cnt - 3'd1;
        state     <= (flush_cnt == 3'd1) ? RUN : FLUSH;
      end
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  // saturating stall and flush cycle counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (lu && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (invalid_IF && !(&flush_cycles)) flush_cycles <= flush_cycles + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of reset, load-use, forwarding, branch flush and reset-in-flush
module tb_hazard_control_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
  logic       rs1_used_ID, rs2_used_ID, regfile_we_EX, mem_read_EX, branch_taken_EX, regfile_we_MEM;
  logic       stall_pc, stall_IF, invalid_IF, stall, invalid_ID, redirect;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [5:0] ctl;
  int checks = 0;
  int errors = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  hazard_control_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .regfile_we_EX(regfile_we_EX), .mem_read_EX(mem_read_EX),
    .branch_taken_EX(branch_taken_EX), .rd_MEM(rd_MEM), .regfile_we_MEM(regfile_we_MEM),
    .stall_pc(stall_pc), .stall_IF(stall_IF), .invalid_IF(invalid_IF), .stall(stall),
    .invalid_ID(invalid_ID), .redirect(redirect),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  always #5 clk = ~clk;
  // {stall_pc, stall_IF, invalid_IF, stall, invalid_ID, redirect}
  assign ctl = {stall_pc, stall_IF, invalid_IF, stall, invalid_ID, redirect};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    rs1_ID = 0; rs2_ID = 0; rd_EX = 0; rd_MEM = 0;
    rs1_used_ID = 0; rs2_used_ID = 0; regfile_we_EX = 0; mem_read_EX = 0;
    branch_taken_EX = 0; regfile_we_MEM = 0;
  endtask

  task automatic set_load_use();
    mem_read_EX = 1; regfile_we_EX = 1; rd_EX = 5; rs1_ID = 5; rs1_used_ID = 1;
  endtask

  task automatic test_reset();
    clear();
    set_load_use();
    branch_taken_EX = 1;
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 6'b001010) begin errors++; $display("FAIL reset_ctl[%0d] got %b want 001010", i, ctl); end
      checks++;
      if (fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL reset_fwd1[%0d] got %b want 00", i, fwd_rs1_sel); end
      @(posedge clk);
    end
    #1;
    rst_n = 1;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_release_killed got %b want 000000", ctl); end
    tick();
  endtask

  task automatic test_load_use();
    clear();
    set_load_use();
    #1;
    checks++;
    if (ctl !== 6'b110010) begin errors++; $display("FAIL lu_rs1_stall got %b want 110010", ctl); end
    checks++;
    if (fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL lu_rs1_nofwd got %b want 00", fwd_rs1_sel); end
    tick();
    rd_MEM = 5; regfile_we_MEM = 1;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_bubble_nostall got %b want 000000", ctl); end
    checks++;
    if (fwd_rs1_sel !== 2'b10) begin errors++; $display("FAIL lu_mem_fwd got %b want 10", fwd_rs1_sel); end
    tick();
    clear();
    mem_read_EX = 1; regfile_we_EX = 1; rd_EX = 7; rs2_ID = 7; rs2_used_ID = 1; rs1_ID = 7;
    #1;
    checks++;
    if (ctl !== 6'b110010) begin errors++; $display("FAIL lu_rs2_stall got %b want 110010", ctl); end
    tick();
    clear();
    tick();
    mem_read_EX = 1; regfile_we_EX = 1; rd_EX = 7; rs1_ID = 7; rs2_ID = 7;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_unused_src got %b want 000000", ctl); end
    rd_EX = 0; rs1_ID = 0; rs1_used_ID = 1;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_x0 got %b want 000000", ctl); end
    tick();
  endtask

  task automatic test_forward();
    clear();
    regfile_we_EX = 1; rd_EX = 3; regfile_we_MEM = 1; rd_MEM = 3; rs2_ID = 3;
    #1;
    checks++;
    if (fwd_rs2_sel !== 2'b01) begin errors++; $display("FAIL fwd_ex_prio got %b want 01", fwd_rs2_sel); end
    checks++;
    if (fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL fwd_rs1_none got %b want 00", fwd_rs1_sel); end
    rd_EX = 4;
    #1;
    checks++;
    if (fwd_rs2_sel !== 2'b10) begin errors++; $display("FAIL fwd_mem_only got %b want 10", fwd_rs2_sel); end
    rs1_ID = 4;
    #1;
    checks++;
    if (fwd_rs1_sel !== 2'b01) begin errors++; $display("FAIL fwd_rs1_ex got %b want 01", fwd_rs1_sel); end
    rd_EX = 0; rd_MEM = 0; rs1_ID = 0; rs2_ID = 0;
    #1;
    checks++;
    if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got %b want 0000", {fwd_rs1_sel, fwd_rs2_sel}); end
    mem_read_EX = 1; rd_EX = 3; rs2_ID = 3;
    #1;
    checks++;
    if (fwd_rs2_sel !== 2'b00) begin errors++; $display("FAIL fwd_no_load got %b want 00", fwd_rs2_sel); end
    tick();
  endtask

  task automatic test_branch();
    clear();
    branch_taken_EX = 1;
    #1;
    checks++;
    if (ctl !== 6'b001011) begin errors++; $display("FAIL br_taken got %b want 001011", ctl); end
    tick();
    checks++;
    if (ctl !== 6'b001010) begin errors++; $display("FAIL br_flush1 got %b want 001010", ctl); end
    tick();
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL br_done got %b want 000000", ctl); end
    tick();
  endtask

  task automatic test_back_to_back();
    clear();
    set_load_use();
    branch_taken_EX = 1;
    #1;
    checks++;
    if (ctl !== 6'b001011) begin errors++; $display("FAIL br_lu_prio got %b want 001011", ctl); end
    tick();
    clear();
    rst_n = 0;
    #1;
    checks++;
    if (ctl !== 6'b001010) begin errors++; $display("FAIL flush_reset_ctl got %b want 001010", ctl); end
    tick();
    rst_n = 1;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin errors++; $display("FAIL flush_reset_run got %b want 000000", ctl); end
    checks++;
    if (dut.flush_cnt !== 3'd0) begin errors++; $display("FAIL flush_reset_cnt got %0d want 0", dut.flush_cnt); end
    tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    clear();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_load_use();
      tick();
      clear();
      tick();
    end
    branch_taken_EX = 1;
    tick();
    clear();
    tick();
    tick();
    checks++;
    if (stall_cycles !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", stall_cycles); end
    checks++;
    if (flush_cycles !== 32'd2) begin errors++; $display("FAIL perf_flush got %0d want 2", flush_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
